// File: rtl/axi3_rd_arbiter.sv
// axi3_rd_arbiter: shares one AXI3 read port between the icache refill
// (0), dcache cached refill (1) and dcache uncached (2) masters. One
// transaction in flight; the grant is locked from AR handshake to RLAST.
// Build option: define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); default is round-robin.

// Per-requester handshake gating: only the owner sees the downstream
// AR/R handshakes, and only while the arbiter is in the matching phase.
module axi3_rd_arb_port (
  input  logic ar_phase_i,
  input  logic r_phase_i,
  input  logic own_i,
  input  logic m_arready_i,
  input  logic m_rvalid_i,
  output logic s_arready_o,
  output logic s_rvalid_o
);
  assign s_arready_o = ar_phase_i & own_i & m_arready_i;
  assign s_rvalid_o  = r_phase_i  & own_i & m_rvalid_i;
endmodule

module axi3_rd_arbiter #(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    s_arvalid,
  output logic [N_REQ-1:0]                    s_arready,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    s_araddr,
  input  logic [N_REQ-1:0][3:0]               s_arlen,
  input  logic [N_REQ-1:0][2:0]               s_arsize,
  input  logic [N_REQ-1:0][1:0]               s_arburst,
  output logic [N_REQ-1:0]                    s_rvalid,
  input  logic [N_REQ-1:0]                    s_rready,
  output logic [DATA_WIDTH-1:0]               s_rdata,
  output logic [1:0]                          s_rresp,
  output logic                                s_rlast,
  output logic                                m_arvalid,
  input  logic                                m_arready,
  output logic [ID_WIDTH-1:0]                 m_arid,
  output logic [ADDR_WIDTH-1:0]               m_araddr,
  output logic [3:0]                          m_arlen,
  output logic [2:0]                          m_arsize,
  output logic [1:0]                          m_arburst,
  input  logic                                m_rvalid,
  output logic                                m_rready,
  input  logic [DATA_WIDTH-1:0]               m_rdata,
  input  logic [1:0]                          m_rresp,
  input  logic                                m_rlast
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] winner;
  logic          any_req;
  logic          ar_phase, r_phase;
  logic          rlast_hs;

  assign any_req  = |s_arvalid;
  assign rlast_hs = r_phase & m_rvalid & m_rready & m_rlast;

  // Winner search: first requester at or after rr_ptr, wrapping at N_REQ.
  // The fixed-priority build pins rr_ptr at 0, which turns this same
  // search into lowest-index-wins.
  always_comb begin
    logic [OW:0]   cand;
    logic [OW-1:0] idx;
    logic          found;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (OW+1)'(k);
      if (cand >= (OW+1)'(N_REQ)) cand = cand - (OW+1)'(N_REQ);
      idx = cand[OW-1:0];
      if (!found && s_arvalid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // State, owner and round-robin pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state: grant in IDLE, wait for AR accept, then hold until RLAST
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) state_d = DATA;
      end
      DATA: begin
        if (rlast_hs) begin
          state_d = IDLE;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
          rr_ptr_d = '0;
`else
          rr_ptr_d = (owner_q == OW'(N_REQ-1)) ? '0 : owner_q + OW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: AR mux from the owner, R payload passes straight through
  always_comb begin
    ar_phase  = (state_q == ADDR);
    r_phase   = (state_q == DATA);
    m_arvalid = ar_phase;
    m_arid    = ID_WIDTH'(owner_q);
    m_araddr  = s_araddr[owner_q];
    m_arlen   = s_arlen[owner_q];
    m_arsize  = s_arsize[owner_q];
    m_arburst = s_arburst[owner_q];
    m_rready  = r_phase & s_rready[owner_q];
    s_rdata   = m_rdata;
    s_rresp   = m_rresp;
    s_rlast   = m_rlast;
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_port
    axi3_rd_arb_port u_port (
      .ar_phase_i  (ar_phase),
      .r_phase_i   (r_phase),
      .own_i       (owner_q == OW'(g)),
      .m_arready_i (m_arready),
      .m_rvalid_i  (m_rvalid),
      .s_arready_o (s_arready[g]),
      .s_rvalid_o  (s_rvalid[g])
    );
  end

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// Randomized scoreboard bench for axi3_rd_arbiter: requester and slave
// agents drive traffic and push expectations; a monitor with a
// transaction-level arbitration model checks every cycle.
module tb_axi3_rd_arbiter;
  localparam int N = 3, AW = 32, DW = 32, IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]         s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N-1:0][AW-1:0] s_araddr;
  logic [N-1:0][3:0]    s_arlen;
  logic [N-1:0][2:0]    s_arsize;
  logic [N-1:0][1:0]    s_arburst;
  logic [DW-1:0]        s_rdata;
  logic [1:0]           s_rresp;
  logic                 s_rlast;
  logic                 m_arvalid, m_arready;
  logic [IW-1:0]        m_arid;
  logic [AW-1:0]        m_araddr;
  logic [3:0]           m_arlen;
  logic [2:0]           m_arsize;
  logic [1:0]           m_arburst;
  logic                 m_rvalid, m_rready;
  logic [DW-1:0]        m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast;

  axi3_rd_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  typedef struct packed {
    logic [1:0]    idx;
    logic [AW-1:0] addr;
    logic [3:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } ar_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_t;

  ar_t           exp_ar[$];
  r_t            exp_r[$];
  logic [IW-1:0] glog[$];
  int n_chk = 0, n_err = 0;

  // agent controls
  int  n_left[N];
  int  req_pct, rdy_pct, arr_pct, rv_pct;
  bit  arr_block, fix_en;
  ar_t fix_ar;
  bit  act[N];
  int  sl_left;

  // model state
  int mph, m_own, m_rr, m_left, beats_cur;

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act_v, exp_v, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int rr);
    int start;
    start = rr;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    start = 0;
`endif
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) return (start + k) % N;
    return 0;
  endfunction

  // Requester and downstream-slave agents
  initial begin : stim
    logic [N-1:0] ar_hs;
    logic         r_hs, mar_hs;
    logic [3:0]   mar_len;
    ar_t          a;
    r_t           b;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    m_rresp = '0; m_rlast = 1'b0; sl_left = 0;
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs   = s_arvalid & s_arready;
      r_hs    = m_rvalid & m_rready;
      mar_hs  = m_arvalid & m_arready;
      mar_len = m_arlen;
      @(posedge clk); #1;
      if (!rst) begin
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        s_arvalid = '0; s_rready = '0; m_arready = 1'b0;
        m_rvalid = 1'b0; m_rlast = 1'b0; sl_left = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (ar_hs[i]) begin act[i] = 1'b0; s_arvalid[i] = 1'b0; end
          if (!act[i] && n_left[i] > 0 && $urandom_range(0, 99) < req_pct) begin
            if (fix_en) a = fix_ar;
            else begin
              a.addr = $urandom; a.len = 4'($urandom_range(0, 15));
              a.size = 3'($urandom); a.burst = 2'($urandom);
            end
            a.idx = 2'(i);
            act[i] = 1'b1; n_left[i]--;
            s_arvalid[i] = 1'b1; s_araddr[i] = a.addr; s_arlen[i] = a.len;
            s_arsize[i] = a.size; s_arburst[i] = a.burst;
            exp_ar.push_back(a);
          end
          s_rready[i] = ($urandom_range(0, 99) < rdy_pct);
        end
        if (mar_hs) sl_left = int'(mar_len) + 1;
        if (r_hs) begin m_rvalid = 1'b0; sl_left--; end
        if (!m_rvalid && sl_left > 0 && $urandom_range(0, 99) < rv_pct) begin
          b.data = $urandom; b.resp = 2'($urandom); b.last = (sl_left == 1);
          m_rvalid = 1'b1; m_rdata = b.data; m_rresp = b.resp; m_rlast = b.last;
          exp_r.push_back(b);
        end
        m_arready = !arr_block && ($urandom_range(0, 99) < arr_pct);
      end
    end
  end

  // Monitor: transaction-level arbitration model and scoreboard checks
  initial begin : mon
    logic [N-1:0] ev;
    ar_t          e;
    r_t           rb;
    int           k;
    mph = 0; m_own = 0; m_rr = 0; m_left = 0; beats_cur = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mph = 0; m_rr = 0;
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_s_arready", s_arready, 0);
        chk("rst_s_rvalid", s_rvalid, 0);
      end else begin
        chk("rdata_pass", s_rdata, m_rdata);
        chk("rresp_pass", s_rresp, m_rresp);
        chk("rlast_pass", s_rlast, m_rlast);
        chk("m_arvalid", m_arvalid, (mph == 1));
        k = -1;
        if (mph == 1) begin
          for (int j = 0; j < exp_ar.size(); j++)
            if (k < 0 && int'(exp_ar[j].idx) == m_own) k = j;
          if (k < 0) chk("ar_expected_present", 0, 1);
          else begin
            e = exp_ar[k];
            chk("m_arid", m_arid, m_own);
            chk("m_araddr", m_araddr, e.addr);
            chk("m_arlen", m_arlen, e.len);
            chk("m_arsize", m_arsize, e.size);
            chk("m_arburst", m_arburst, e.burst);
          end
          ev = '0; ev[m_own] = m_arready;
          chk("s_arready", s_arready, ev);
        end else chk("s_arready_idle", s_arready, 0);
        if (mph == 2) begin
          ev = '0; ev[m_own] = m_rvalid;
          chk("s_rvalid", s_rvalid, ev);
          chk("m_rready", m_rready, s_rready[m_own]);
        end else begin
          chk("s_rvalid_idle", s_rvalid, 0);
          chk("m_rready_idle", m_rready, 0);
        end
        case (mph)
          0: if (|s_arvalid) begin m_own = pick(s_arvalid, m_rr); mph = 1; end
          1: if (m_arready) begin
               glog.push_back(m_arid);
               if (k >= 0) begin m_left = int'(exp_ar[k].len) + 1; exp_ar.delete(k); end
               beats_cur = 0; mph = 2;
             end
          default: if (m_rvalid && s_rready[m_own]) begin
               if (exp_r.size() == 0) chk("r_expected_present", 0, 1);
               else begin
                 rb = exp_r.pop_front();
                 chk("beat_data", s_rdata, rb.data);
                 chk("beat_resp", s_rresp, rb.resp);
                 chk("beat_last", s_rlast, rb.last);
               end
               chk("rlast_position", m_rlast, (m_left == 1));
               m_left--; beats_cur++;
               if (m_rlast) begin
                 mph = 0;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
                 m_rr = 0;
`else
                 m_rr = (m_own + 1) % N;
`endif
               end
             end
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #3;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (c < budget && !(n_left[0] == 0 && n_left[1] == 0 && n_left[2] == 0 &&
           !act[0] && !act[1] && !act[2] && mph == 0 && sl_left == 0 && !m_rvalid)) begin
      cyc(); c++;
    end
    chk("drain_timeout", (c >= budget), 0);
    cyc();
  endtask

  task automatic wait_grants(input int n);
    int c = 0;
    while (glog.size() < n && c < 1000) begin cyc(); c++; end
    chk("grant_timeout", (glog.size() >= n), 1);
  endtask

  task automatic speed(input int rq, input int rd, input int ar, input int rv);
    req_pct = rq; rdy_pct = rd; arr_pct = ar; rv_pct = rv;
  endtask

  initial begin : wdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int g0, c;
    rst = 1'b0; arr_block = 1'b0; fix_en = 1'b0; fix_ar = '0;
    for (int i = 0; i < N; i++) n_left[i] = 0;
    speed(0, 0, 0, 0);
    #1;
    chk("reset_m_arvalid", m_arvalid, 0);
    chk("reset_s_arready", s_arready, 0);
    chk("reset_s_rvalid", s_rvalid, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    // all three requesters at once, kept asserted
    speed(100, 100, 100, 100);
    g0 = glog.size();
    n_left = '{3, 3, 3};
    wait_grants(g0 + 4);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    chk("prio_grant0", glog[g0], 0); chk("prio_grant1", glog[g0+1], 0);
    chk("prio_grant2", glog[g0+2], 0); chk("prio_grant3", glog[g0+3], 1);
`else
    chk("rr_grant0", glog[g0], 0); chk("rr_grant1", glog[g0+1], 1);
    chk("rr_grant2", glog[g0+2], 2); chk("rr_grant3", glog[g0+3], 0);
`endif
    drain(2000);

    // single 8-beat request from requester 1
    fix_en = 1'b1;
    fix_ar.addr = 32'h1FC0_0100; fix_ar.len = 4'd7; fix_ar.size = 3'd2; fix_ar.burst = 2'd1;
    g0 = glog.size();
    n_left[1] = 1;
    drain(500);
    chk("single_grant", glog[g0], 1);
    chk("single_beats", beats_cur, 8);

    // pointer now past 1: lone requester 0 wins across the wrap
    g0 = glog.size();
    n_left[0] = 1;
    drain(500);
    chk("wrap_grant", glog[g0], 0);
    g0 = glog.size();
    n_left = '{1, 1, 1};
    wait_grants(g0 + 1);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    chk("after_wrap_grant", glog[g0], 0);
`else
    chk("after_wrap_grant", glog[g0], 1);
`endif
    drain(500);

    // AR backpressure then R stalls from requester rready
    fix_en = 1'b0;
    arr_block = 1'b1;
    speed(100, 50, 100, 100);
    n_left[2] = 1;
    c = 0;
    while (mph != 1 && c < 100) begin cyc(); c++; end
    chk("bp_reached_addr", (mph == 1), 1);
    repeat (5) cyc();
    chk("bp_s_arready_low", s_arready[2], 0);
    chk("bp_arvalid_held", m_arvalid, 1);
    arr_block = 1'b0;
    drain(500);

    // randomized traffic
    speed(30, 60, 60, 70);
    n_left = '{40, 40, 40};
    drain(30000);

    // reset in the middle of an 8-beat burst
    speed(100, 100, 100, 100);
    fix_en = 1'b1;
    n_left[1] = 1;
    c = 0;
    while (!(mph == 2 && beats_cur == 3) && c < 200) begin cyc(); c++; end
    chk("mid_burst_reached", (mph == 2 && beats_cur == 3), 1);
    chk("pre_rst_m_rready", m_rready, 1);
    chk("pre_rst_s_rvalid", s_rvalid, 3'b010);
    rst = 1'b0;
    #1;
    chk("async_rst_m_rready", m_rready, 0);
    chk("async_rst_s_rvalid", s_rvalid, 0);
    chk("async_rst_m_arvalid", m_arvalid, 0);
    chk("async_rst_s_arready", s_arready, 0);
    exp_ar.delete(); exp_r.delete();
    for (int i = 0; i < N; i++) n_left[i] = 0;
    repeat (2) cyc();
    rst = 1'b1;
    fix_en = 1'b0;
    g0 = glog.size();
    n_left = '{1, 1, 1};
    wait_grants(g0 + 1);
    chk("post_rst_grant", glog[g0], 0);
    drain(1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
